// File: rtl/bsearch_pkg.sv
// Shared types for the binary-search controller: FSM state encoding and
// reset value of the probe operand.
package bsearch_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StProbe,
      StDone
   } state_e;

   localparam int unsigned ProbeRst = 0;

endpackage

// File: rtl/comparator_4.sv
// Combinational 4-bit magnitude comparator; the peer whose flags the
// binary-search controller consumes.
module comparator_4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic       gt,
   output logic       lt,
   output logic       eq
);

   assign gt = (a > b);
   assign lt = (a < b);
   assign eq = (a == b);

endmodule

// File: rtl/bsearch_ctrl.sv
// Binary-search controller: drives a comparator probe operand and narrows
// [lo, hi] on gt/lt flags until eq, exhaustion or an illegal flag pattern.
module bsearch_ctrl
   import bsearch_pkg::*;
#(
   parameter int unsigned WIDTH  = 4,
   parameter int unsigned ITER_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              cmp_gt,
   input  logic              cmp_lt,
   input  logic              cmp_eq,
   output logic [WIDTH-1:0]  probe,
   output logic              busy,
   output logic              done,
   output logic              found,
   output logic              err,
   output logic [WIDTH-1:0]  result,
   output logic [ITER_W-1:0] n_probes
);

   localparam logic [WIDTH:0] One    = (WIDTH+1)'(1);
   localparam logic [WIDTH:0] HiInit = {1'b0, {WIDTH{1'b1}}};

   state_e           state;
   logic [WIDTH:0]   lo, hi;
   logic [WIDTH:0]   lo_nxt, hi_nxt;
   logic [WIDTH:0]   probe_ext;
   logic [WIDTH+1:0] mid_sum;
   logic             exhausted;
   logic [2:0]       flags;

   assign probe_ext = {1'b0, probe};
   assign flags     = {cmp_gt, cmp_lt, cmp_eq};

   // hi wraps to all-ones when probe=0 steps below zero; its MSB marks exhaustion.
   always_comb begin
      lo_nxt = lo;
      hi_nxt = hi;
      if (flags == 3'b100) hi_nxt = probe_ext - One;
      if (flags == 3'b010) lo_nxt = probe_ext + One;
      exhausted = hi_nxt[WIDTH] || (lo_nxt > hi_nxt);
      mid_sum   = {1'b0, lo_nxt} + {1'b0, hi_nxt};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= StIdle;
         lo       <= '0;
         hi       <= '0;
         probe    <= WIDTH'(ProbeRst);
         busy     <= 1'b0;
         done     <= 1'b0;
         found    <= 1'b0;
         err      <= 1'b0;
         result   <= '0;
         n_probes <= '0;
      end else begin
         unique case (state)
            StIdle: begin
               if (start) begin
                  state    <= StProbe;
                  lo       <= '0;
                  hi       <= HiInit;
                  probe    <= WIDTH'(HiInit >> 1);
                  busy     <= 1'b1;
                  found    <= 1'b0;
                  err      <= 1'b0;
                  result   <= '0;
                  n_probes <= '0;
               end
            end
            StProbe: begin
               n_probes <= n_probes + ITER_W'(1);
               case (flags)
                  3'b001: begin
                     result <= probe;
                     found  <= 1'b1;
                     state  <= StDone;
                     busy   <= 1'b0;
                     done   <= 1'b1;
                  end
                  3'b100, 3'b010: begin
                     lo <= lo_nxt;
                     hi <= hi_nxt;
                     if (exhausted) begin
                        state <= StDone;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end else begin
                        probe <= WIDTH'(mid_sum >> 1);
                     end
                  end
                  default: begin
                     err   <= 1'b1;
                     found <= 1'b0;
                     state <= StDone;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               endcase
            end
            StDone: begin
               done  <= 1'b0;
               state <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_bsearch_ctrl.sv
// Self-checking bench for bsearch_ctrl against a comparator_4 peer; expected
// search outcomes are queued at start and checked when done pulses.
module tb_bsearch_ctrl;

   localparam int W = 4;

   typedef struct {
      int found;
      int err;
      int result;
      int n;
      int start_cyc;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst, start;
   logic [W-1:0] secret;
   int           ovr;
   logic         c_gt, c_lt, c_eq;
   logic         cmp_gt, cmp_lt, cmp_eq;
   logic [W-1:0] probe, result;
   logic         busy, done, found, err;
   logic [2:0]   n_probes;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   done_cnt = 0;
   exp_t sb[$];
   exp_t mon_e;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   comparator_4 u_cmp (
      .a (probe),
      .b (secret),
      .gt(c_gt),
      .lt(c_lt),
      .eq(c_eq)
   );

   // ovr=1: force gt when probe hits 0; ovr=2: force illegal gt+lt.
   always_comb begin
      cmp_gt = c_gt;
      cmp_lt = c_lt;
      cmp_eq = c_eq;
      if (ovr == 1 && probe == '0) begin
         cmp_gt = 1'b1;
         cmp_lt = 1'b0;
         cmp_eq = 1'b0;
      end else if (ovr == 2) begin
         cmp_gt = 1'b1;
         cmp_lt = 1'b1;
         cmp_eq = 1'b0;
      end
   end

   bsearch_ctrl #(.WIDTH(W), .ITER_W(3)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .cmp_gt  (cmp_gt),
      .cmp_lt  (cmp_lt),
      .cmp_eq  (cmp_eq),
      .probe   (probe),
      .busy    (busy),
      .done    (done),
      .found   (found),
      .err     (err),
      .result  (result),
      .n_probes(n_probes)
   );

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic exp_t model(input int s, input int mode);
      exp_t e;
      int lo, hi, p;
      bit stop;
      e = '{default: 0};
      lo = 0;
      hi = (1 << W) - 1;
      stop = 0;
      while (!stop) begin
         e.n++;
         p = (lo + hi) / 2;
         if (mode == 2) begin
            e.err = 1;
            stop = 1;
         end else if (p == s && !(mode == 1 && p == 0)) begin
            e.found = 1;
            e.result = p;
            stop = 1;
         end else begin
            if (p > s || (mode == 1 && p == 0)) hi = p - 1;
            else lo = p + 1;
            if (lo > hi) stop = 1;
         end
      end
      return e;
   endfunction

   // Scoreboard consumer: every done pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (done) begin
         done_cnt++;
         check("busy_in_done", busy, 0);
         if (sb.size() == 0) begin
            check("spurious_done", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            check("found", found, mon_e.found);
            check("err", err, mon_e.err);
            check("result", result, mon_e.result);
            check("n_probes", n_probes, mon_e.n);
            check("latency", cyc - mon_e.start_cyc, mon_e.n + 1);
         end
      end
   end

   task automatic check_reset_state(input string tag);
      check({tag, "_probe"}, probe, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_found"}, found, 0);
      check({tag, "_err"}, err, 0);
      check({tag, "_result"}, result, 0);
      check({tag, "_nprobes"}, n_probes, 0);
   endtask

   // Called at a negedge in IDLE; returns at the negedge of the first PROBE cycle.
   task automatic launch(input int s, input int mode);
      exp_t e;
      secret = W'(s);
      ovr = mode;
      e = model(s, mode);
      e.start_cyc = cyc;
      sb.push_back(e);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("probe_first", probe, 7);
      check("busy_first", busy, 1);
   endtask

   // Returns at the negedge of the DONE cycle, or one cycle later if advance.
   task automatic wait_done(input bit advance);
      int k;
      k = 0;
      while (!done && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (!done) check("done_timeout", 0, 1);
      if (advance) @(negedge clk);
   endtask

   initial begin
      exp_t dummy;
      int   d0;
      rst = 1'b1;
      start = 1'b0;
      secret = '0;
      ovr = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check_reset_state("rst");

      launch(7, 0);
      wait_done(1);
      launch(15, 0);
      wait_done(1);
      launch(0, 0);
      wait_done(1);
      launch(0, 1);
      wait_done(1);
      launch(5, 2);
      wait_done(1);

      // Reset mid-search: rst high in cycle 3, reset state visible in cycle 4.
      launch(15, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset_state("midrst");
      dummy = sb.pop_back();
      d0 = done_cnt;
      repeat (8) @(negedge clk);
      check("no_done_after_rst", done_cnt, d0);
      launch(15, 0);
      wait_done(1);

      // start during PROBE and held through DONE; second search begins from IDLE.
      launch(15, 0);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(0);
      begin
         exp_t e;
         secret = W'(9);
         ovr = 0;
         e = model(9, 0);
         e.start_cyc = cyc + 1;
         sb.push_back(e);
      end
      start = 1'b1;
      @(negedge clk);
      check("idle_after_done", busy, 0);
      @(negedge clk);
      start = 1'b0;
      check("probe_b2b", probe, 7);
      check("busy_b2b", busy, 1);
      wait_done(1);
      repeat (3) @(negedge clk);

      check("done_count", done_cnt, 8);
      check("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
